ram_mar: RTL and testbench
==========================

Name: ram_mar

Overview:
- Parametrised successor to the CPU's 16x8 bus RAM.
- Adds an integrated memory address register (MAR) loaded from the shared bus.
- Adds a clear-on-reset sweep and a program-load mode that fills memory sequentially from an external loader through a valid/ready handshake.
- Sits on the CPU's shared tri-state data bus, between the controller's control lines and the program loader.

Parameters:
- DATA_W, 8, width of each word and of the bus
- ADDR_W, 4, address width; depth = 2^ADDR_W words
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the sweep, contents undefined at power-up

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- bus  inout  DATA_W  shared CPU data bus
- mar_in  input  1  load MAR from bus[ADDR_W-1:0] (active high)
- we  input  1  write bus into mem[MAR] (active high)
- oe_n  input  1  drive mem[MAR] onto bus (active low)
- prog_mode  input  1  request program-load mode
- prog_data  input  DATA_W  loader data word
- prog_valid  input  1  loader word valid
- prog_ready  output  1  block accepts loader words
- busy  output  1  clear sweep in progress
- mar_out  output  ADDR_W  current MAR value, for debug/LEDs

Behaviour:
- One clock; reset is synchronous and active-high.
- States:
  - CLEAR: zero sweep
  - RUN: normal bus operation
  - PROG: sequential program load
- Reset values:
  - MAR=0, clr_ptr=0, prog_ptr=0
  - busy=1 if CLEAR_ON_RESET else 0
  - prog_ready=0
  - bus released (Z)
  - state = CLEAR if CLEAR_ON_RESET else RUN
- rst dominates all other inputs. Asserting it mid-sweep or mid-load restarts from the reset state. Words already written are kept, except where the new sweep overwrites them.
- CLEAR:
  - Each cycle writes 0 to mem[clr_ptr], then increments clr_ptr.
  - After writing word 2^ADDR_W-1, moves to RUN on the next edge and busy drops. Total busy time = 2^ADDR_W cycles.
  - mar_in, we, oe_n and prog_mode are ignored; bus is not driven.
- RUN:
  - Read is combinational: bus = mem[MAR] when oe_n=0 and we=0; otherwise Z.
  - oe_n=0 together with we=1 is contention. The block must not drive the bus, and the write proceeds.
  - mar_in=1: MAR <= bus[ADDR_W-1:0] at the edge. Upper bus bits are ignored. The new address is visible on reads in the next cycle.
  - we=1: mem[MAR] <= bus at the edge.
  - mar_in and we in the same cycle: the write uses the old MAR, then MAR updates.
  - prog_mode=1 at an edge: go to PROG and set prog_ptr <= 0. mar_in/we in that same cycle are still honoured.
- PROG:
  - prog_ready=1. The bus is not driven; mar_in, we and oe_n are ignored.
  - prog_valid=1 and prog_ready=1 at an edge: mem[prog_ptr] <= prog_data, prog_ptr++.
  - prog_ptr wraps from 2^ADDR_W-1 to 0; further words overwrite from address 0.
  - prog_mode=0 at an edge: go to RUN and prog_ready=0 from the next cycle. A handshake in that exit cycle still commits.
  - MAR is unchanged by PROG.
- mar_out always reflects MAR.
- Memory is an array of 2^ADDR_W x DATA_W registers with no reset, except through the sweep.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, ADDR_W=4 -> busy high for exactly 16 cycles. After that, MAR loaded to each address 0..15 with oe_n=0 reads 0x00.
2. RUN: put 0x03 on bus with mar_in=1, then 0xA5 with we=1, then release bus with oe_n=0 -> bus reads 0xA5 and mar_out=3. Setting mar_in=1 and we=1 together with bus=0x07 -> mem[3]=0x07 and MAR=7.
3. PROG: prog_mode=1, then stream 0x11,0x22,0x33 with prog_valid toggling on and off -> only the handshaked words are written to addresses 0,1,2. After exit, reads of 0..2 return 0x11,0x22,0x33.
4. PROG wrap: stream 17 words (0x00..0x10) -> mem[0]=0x10 and mem[1..15]=0x01..0x0F.
5. Contention: oe_n=0, we=1, external bus=0x5A -> the block never drives the bus and mem[MAR]=0x5A. Bus inputs during CLEAR/PROG have no effect on memory or MAR.
6. Mid-load reset: assert rst during PROG after 2 words -> prog_ready=0 next cycle, 16-cycle sweep runs, and all words read 0x00 afterwards. Repeat with CLEAR_ON_RESET=0 -> RUN immediately and busy never asserts.

Source files
------------

// File: rtl/ram_mar.sv
// ---------------------------------------------------------------------------
// ram_mar
// Parametrised bus RAM with an integrated memory address register (MAR).
// It sits on the CPU's shared tri-state data bus. After reset it can sweep
// every word to zero. A program-load mode fills memory sequentially from an
// external loader through a valid/ready handshake.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous, active-high reset (dominates every other input)
//   bus         shared CPU data bus (DATA_W bits, tri-state)
//   mar_in      load MAR from bus[ADDR_W-1:0]
//   we          write bus into mem[MAR]
//   oe_n        drive mem[MAR] onto bus (active low)
//   prog_mode   request program-load mode
//   prog_data   loader data word
//   prog_valid  loader word valid
//   prog_ready  block accepts loader words (high only in program-load mode)
//   busy        clear sweep in progress
//   mar_out     current MAR value, for debug/LEDs
// ---------------------------------------------------------------------------
module ram_mar #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              mar_in,
    input  logic              we,
    input  logic              oe_n,
    input  logic              prog_mode,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] mar_out
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_PROG
    } stateT;

    stateT             r_state;
    stateT             w_stateNext;
    logic [ADDR_W-1:0] r_mar;
    logic [ADDR_W-1:0] r_clrPtr;
    logic [ADDR_W-1:0] r_progPtr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [DATA_W-1:0] w_memData;
    logic              w_busDrive;

    // Next-state logic. The sweep leaves CLEAR on the same edge that writes
    // the last word. Program mode is entered and left purely on prog_mode.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_CLEAR: if (r_clrPtr == {ADDR_W{1'b1}}) w_stateNext = ST_RUN;
            ST_RUN:   if (prog_mode)                  w_stateNext = ST_PROG;
            ST_PROG:  if (!prog_mode)                 w_stateNext = ST_RUN;
            default:                                  w_stateNext = ST_RUN;
        endcase
    end

    // State, MAR and pointer registers. In RUN, the MAR load and the entry
    // into PROG are independent, so both happen when requested together.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET) r_state <= ST_CLEAR;
            else                r_state <= ST_RUN;
            r_mar     <= '0;
            r_clrPtr  <= '0;
            r_progPtr <= '0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                ST_CLEAR: r_clrPtr <= r_clrPtr + 1'b1;
                ST_RUN: begin
                    if (mar_in)    r_mar     <= bus[ADDR_W-1:0];
                    if (prog_mode) r_progPtr <= '0;
                end
                ST_PROG: if (prog_valid) r_progPtr <= r_progPtr + 1'b1;
                default: ;
            endcase
        end
    end

    // Single memory write port, shared by the sweep, bus writes and the
    // loader. A bus write in RUN always uses the MAR value from before this
    // edge, so a same-cycle mar_in cannot redirect it. prog_ready equals
    // "state is PROG", so prog_valid alone completes the handshake there.
    always_comb begin
        w_memWe   = 1'b0;
        w_memAddr = r_mar;
        w_memData = bus;
        if (!rst) begin
            case (r_state)
                ST_CLEAR: begin
                    w_memWe   = 1'b1;
                    w_memAddr = r_clrPtr;
                    w_memData = '0;
                end
                ST_RUN: w_memWe = we;
                ST_PROG: begin
                    w_memWe   = prog_valid;
                    w_memAddr = r_progPtr;
                    w_memData = prog_data;
                end
                default: ;
            endcase
        end
    end

    // Memory array has no reset of its own; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (w_memWe) r_mem[w_memAddr] <= w_memData;
    end

    // Combinational read onto the bus, only in RUN. The block never drives
    // while we is high, so an external writer never fights the RAM.
    assign w_busDrive = !rst && (r_state == ST_RUN) && !oe_n && !we;
    assign bus        = w_busDrive ? r_mem[r_mar] : {DATA_W{1'bz}};

    assign prog_ready = (r_state == ST_PROG);
    assign busy       = (r_state == ST_CLEAR);
    assign mar_out    = r_mar;

endmodule

// File: tb/tb_ram_mar.sv
// ---------------------------------------------------------------------------
// tb_ram_mar
// Self-checking bench for ram_mar. The main instance uses CLEAR_ON_RESET=1.
// A second instance uses CLEAR_ON_RESET=0 for the no-sweep reset behaviour.
// Expected memory contents come from a plain array model that the stimulus
// tasks update as they issue each write or handshake.
// ---------------------------------------------------------------------------
module tb_ram_mar;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (CLEAR_ON_RESET=1)
    logic          rst, marIn, we, oeN, progMode, progValid;
    logic [DW-1:0] progData;
    logic          progReady, busy;
    logic [AW-1:0] marOut;
    wire  [DW-1:0] bus;
    logic          busEn;
    logic [DW-1:0] busVal;
    assign bus = busEn ? busVal : {DW{1'bz}};

    // Second instance (CLEAR_ON_RESET=0)
    logic          rst0, marIn0, we0, oeN0, progMode0, progValid0;
    logic [DW-1:0] progData0;
    logic          progReady0, busy0;
    logic [AW-1:0] marOut0;
    wire  [DW-1:0] bus0;
    logic          bus0En;
    logic [DW-1:0] bus0Val;
    assign bus0 = bus0En ? bus0Val : {DW{1'bz}};

    ram_mar #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .mar_in(marIn), .we(we), .oe_n(oeN),
        .prog_mode(progMode), .prog_data(progData), .prog_valid(progValid),
        .prog_ready(progReady), .busy(busy), .mar_out(marOut)
    );

    ram_mar #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) u_dut0 (
        .clk(clk), .rst(rst0), .bus(bus0), .mar_in(marIn0), .we(we0), .oe_n(oeN0),
        .prog_mode(progMode0), .prog_data(progData0), .prog_valid(progValid0),
        .prog_ready(progReady0), .busy(busy0), .mar_out(marOut0)
    );

    int            checks = 0;
    int            passed = 0;
    logic [DW-1:0] refMem [DEPTH];
    logic [AW-1:0] refMar;
    logic          busy0Seen = 1'b0;

    // The no-sweep instance must never report busy, whatever it is doing.
    always @(negedge clk) begin
        if (busy0 === 1'b1) busy0Seen <= 1'b1;
    end

    // Every input change happens just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-cycle bus write: load MAR (junk in the upper bits), then write.
    task automatic busWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        busEn  = 1'b1;
        busVal = {4'($urandom_range(0, 15)), a};
        marIn  = 1'b1;
        tick();
        marIn  = 1'b0;
        busVal = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
        busEn  = 1'b0;
        refMem[a] = d;
        refMar    = a;
    endtask

    // Load MAR, release the bus, enable output and capture the read value.
    task automatic busRead(input logic [AW-1:0] a, output logic [DW-1:0] d);
        busEn  = 1'b1;
        busVal = {4'($urandom_range(0, 15)), a};
        marIn  = 1'b1;
        tick();
        marIn  = 1'b0;
        busEn  = 1'b0;
        oeN    = 1'b0;
        #1;
        d      = bus;
        oeN    = 1'b1;
        refMar = a;
    endtask

    // Reset plus the full sweep. Every control input is asserted during the
    // sweep to show that CLEAR ignores them.
    task automatic test_reset();
        int            cnt;
        logic          busOk;
        logic [DW-1:0] rd;
        rst    = 1'b1;
        busEn  = 1'b1;
        busVal = 8'h00;
        tick();
        tick();
        checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b want 1", busy); else passed++;
        checks++; if (progReady !== 1'b0) $display("[TB] FAIL reset_prog_ready: got %b want 0", progReady); else passed++;
        checks++; if (marOut !== 4'h0) $display("[TB] FAIL reset_mar: got %h want 0", marOut); else passed++;
        checks++; if (bus !== 8'h00) $display("[TB] FAIL reset_bus_released: got %h want 00", bus); else passed++;
        rst      = 1'b0;
        marIn    = 1'b1;
        we       = 1'b1;
        oeN      = 1'b0;
        progMode = 1'b1;
        busVal   = 8'($urandom) | 8'h01;
        cnt      = 1;
        busOk    = 1'b1;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            tick();
            if (bus !== busVal) busOk = 1'b0;
            if (busy === 1'b1) cnt++;
        end
        marIn    = 1'b0;
        we       = 1'b0;
        oeN      = 1'b1;
        progMode = 1'b0;
        busEn    = 1'b0;
        checks++; if (cnt != 16) $display("[TB] FAIL sweep_length: got %0d cycles want 16", cnt); else passed++;
        checks++; if (!busOk) $display("[TB] FAIL sweep_bus_undriven: bus disturbed, want %h", busVal); else passed++;
        checks++; if (marOut !== 4'h0) $display("[TB] FAIL sweep_mar_ignored: got %h want 0", marOut); else passed++;
        checks++; if (progReady !== 1'b0) $display("[TB] FAIL sweep_no_prog: got %b want 0", progReady); else passed++;
        for (int a = 0; a < DEPTH; a++) refMem[a] = 8'h00;
        refMar = 4'h0;
        for (int a = 0; a < DEPTH; a++) begin
            busRead(4'(a), rd);
            checks++; if (rd !== refMem[a]) $display("[TB] FAIL sweep_zero[%0d]: got %h want %h", a, rd, refMem[a]); else passed++;
        end
    endtask

    // Directed RUN cases, then random writes and reads against the model.
    task automatic test_run();
        logic [DW-1:0] rd;
        logic [AW-1:0] a;
        busEn  = 1'b1;
        busVal = 8'h03;
        marIn  = 1'b1;
        tick();
        marIn  = 1'b0;
        busVal = 8'hA5;
        we     = 1'b1;
        tick();
        we     = 1'b0;
        busEn  = 1'b0;
        oeN    = 1'b0;
        refMem[3] = 8'hA5;
        refMar    = 4'h3;
        #1;
        checks++; if (bus !== refMem[3]) $display("[TB] FAIL run_read_a5: got %h want %h", bus, refMem[3]); else passed++;
        checks++; if (marOut !== refMar) $display("[TB] FAIL run_mar_3: got %h want %h", marOut, refMar); else passed++;
        oeN    = 1'b1;
        // Same-cycle MAR load and write: the write lands at the old address.
        busEn  = 1'b1;
        busVal = 8'h07;
        marIn  = 1'b1;
        we     = 1'b1;
        tick();
        marIn  = 1'b0;
        we     = 1'b0;
        busEn  = 1'b0;
        refMem[refMar] = 8'h07;
        refMar         = 4'h7;
        checks++; if (marOut !== refMar) $display("[TB] FAIL run_mar_7: got %h want %h", marOut, refMar); else passed++;
        busRead(4'h3, rd);
        checks++; if (rd !== refMem[3]) $display("[TB] FAIL run_write_old_mar: got %h want %h", rd, refMem[3]); else passed++;
        for (int i = 0; i < 8; i++) busWrite(4'($urandom_range(0, 15)), 8'($urandom));
        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom_range(0, 15));
            busRead(a, rd);
            checks++; if (rd !== refMem[a]) $display("[TB] FAIL run_random[%0d]: got %h want %h", a, rd, refMem[a]); else passed++;
        end
    endtask

    // oe_n=0 with we=1: the external writer owns the bus and the write lands.
    task automatic test_contention();
        logic [DW-1:0] rd;
        busWrite(4'h9, 8'hA5);
        busEn  = 1'b1;
        busVal = 8'h5A;
        oeN    = 1'b0;
        we     = 1'b1;
        #1;
        checks++; if (bus !== 8'h5A) $display("[TB] FAIL contention_no_drive: got %h want 5a", bus); else passed++;
        tick();
        we     = 1'b0;
        oeN    = 1'b1;
        busEn  = 1'b0;
        refMem[9] = 8'h5A;
        busRead(4'h9, rd);
        checks++; if (rd !== refMem[9]) $display("[TB] FAIL contention_write: got %h want %h", rd, refMem[9]); else passed++;
    endtask

    // Three words with valid toggling; bus controls are driven but ignored.
    task automatic test_prog();
        logic [DW-1:0] words [3];
        logic [DW-1:0] rd;
        logic [AW-1:0] keptMar;
        int            ptr;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        keptMar  = refMar;
        progMode = 1'b1;
        tick();
        checks++; if (progReady !== 1'b1) $display("[TB] FAIL prog_ready_high: got %b want 1", progReady); else passed++;
        marIn  = 1'b1;
        we     = 1'b1;
        oeN    = 1'b0;
        busEn  = 1'b1;
        busVal = ~refMem[keptMar];
        #1;
        checks++; if (bus !== busVal) $display("[TB] FAIL prog_bus_undriven: got %h want %h", bus, busVal); else passed++;
        ptr = 0;
        for (int i = 0; i < 3; i++) begin
            progValid = 1'b0;
            progData  = 8'($urandom);
            tick();
            progValid = 1'b1;
            progData  = words[i];
            tick();
            refMem[ptr] = words[i];
            ptr = ptr + 1;
        end
        progValid = 1'b0;
        progMode  = 1'b0;
        tick();
        marIn = 1'b0;
        we    = 1'b0;
        oeN   = 1'b1;
        busEn = 1'b0;
        checks++; if (progReady !== 1'b0) $display("[TB] FAIL prog_ready_low: got %b want 0", progReady); else passed++;
        checks++; if (marOut !== keptMar) $display("[TB] FAIL prog_mar_kept: got %h want %h", marOut, keptMar); else passed++;
        busRead(keptMar, rd);
        checks++; if (rd !== refMem[keptMar]) $display("[TB] FAIL prog_ignored_we: got %h want %h", rd, refMem[keptMar]); else passed++;
        for (int a = 0; a < 3; a++) begin
            busRead(4'(a), rd);
            checks++; if (rd !== refMem[a]) $display("[TB] FAIL prog_word[%0d]: got %h want %h", a, rd, refMem[a]); else passed++;
        end
    endtask

    // 17 words with random gaps; the last one shares the exit cycle.
    task automatic test_prog_wrap();
        logic [DW-1:0] rd;
        int            ptr;
        progMode = 1'b1;
        tick();
        ptr = 0;
        for (int i = 0; i < 17; i++) begin
            repeat ($urandom_range(0, 2)) begin
                progValid = 1'b0;
                progData  = 8'($urandom);
                tick();
            end
            progValid = 1'b1;
            progData  = 8'(i);
            if (i == 16) progMode = 1'b0;
            tick();
            refMem[ptr] = 8'(i);
            ptr = (ptr + 1) % DEPTH;
        end
        progValid = 1'b0;
        checks++; if (progReady !== 1'b0) $display("[TB] FAIL wrap_exit_ready: got %b want 0", progReady); else passed++;
        for (int a = 0; a < DEPTH; a++) begin
            busRead(4'(a), rd);
            checks++; if (rd !== refMem[a]) $display("[TB] FAIL wrap_word[%0d]: got %h want %h", a, rd, refMem[a]); else passed++;
        end
    endtask

    // Reset during a load restarts the sweep and clears everything.
    task automatic test_mid_reset();
        logic [DW-1:0] rd;
        int            cnt;
        progMode = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            progValid = 1'b1;
            progData  = 8'($urandom) | 8'h80;
            tick();
        end
        progData = 8'hEE;
        rst      = 1'b1;
        tick();
        checks++; if (progReady !== 1'b0) $display("[TB] FAIL midreset_ready: got %b want 0", progReady); else passed++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL midreset_busy: got %b want 1", busy); else passed++;
        rst       = 1'b0;
        progMode  = 1'b0;
        progValid = 1'b0;
        cnt       = 1;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            tick();
            if (busy === 1'b1) cnt++;
        end
        checks++; if (cnt != 16) $display("[TB] FAIL midreset_sweep: got %0d cycles want 16", cnt); else passed++;
        for (int a = 0; a < DEPTH; a++) refMem[a] = 8'h00;
        for (int a = 0; a < DEPTH; a++) begin
            busRead(4'(a), rd);
            checks++; if (rd !== refMem[a]) $display("[TB] FAIL midreset_zero[%0d]: got %h want %h", a, rd, refMem[a]); else passed++;
        end
    endtask

    // CLEAR_ON_RESET=0: RUN right after reset, no busy, loaded words survive.
    task automatic test_no_clear();
        logic [DW-1:0] loaded;
        rst0 = 1'b1;
        tick();
        checks++; if (progReady0 !== 1'b0) $display("[TB] FAIL noclr_ready: got %b want 0", progReady0); else passed++;
        checks++; if (marOut0 !== 4'h0) $display("[TB] FAIL noclr_mar: got %h want 0", marOut0); else passed++;
        rst0    = 1'b0;
        bus0En  = 1'b1;
        bus0Val = 8'h05;
        marIn0  = 1'b1;
        tick();
        marIn0  = 1'b0;
        bus0Val = 8'h3C;
        we0     = 1'b1;
        tick();
        we0     = 1'b0;
        bus0En  = 1'b0;
        oeN0    = 1'b0;
        #1;
        checks++; if (bus0 !== 8'h3C) $display("[TB] FAIL noclr_first_write: got %h want 3c", bus0); else passed++;
        oeN0       = 1'b1;
        loaded     = 8'($urandom);
        progMode0  = 1'b1;
        tick();
        progValid0 = 1'b1;
        progData0  = loaded;
        tick();
        progData0  = ~loaded;
        rst0       = 1'b1;
        tick();
        rst0       = 1'b0;
        progMode0  = 1'b0;
        progValid0 = 1'b0;
        checks++; if (progReady0 !== 1'b0) $display("[TB] FAIL noclr_reset_ready: got %b want 0", progReady0); else passed++;
        bus0En  = 1'b1;
        bus0Val = 8'h00;
        marIn0  = 1'b1;
        tick();
        marIn0  = 1'b0;
        bus0En  = 1'b0;
        oeN0    = 1'b0;
        #1;
        checks++; if (bus0 !== loaded) $display("[TB] FAIL noclr_word_kept: got %h want %h", bus0, loaded); else passed++;
        oeN0 = 1'b1;
        repeat (4) tick();
        checks++; if (busy0Seen !== 1'b0) $display("[TB] FAIL noclr_busy_never: got %b want 0", busy0Seen); else passed++;
    endtask

    // Global bound so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, %0d/%0d", passed, checks);
        $fatal(1, "[TB] timeout");
    end

    // Test sequence
    initial begin
        rst = 1'b1;  marIn = 1'b0;  we = 1'b0;  oeN = 1'b1;
        progMode = 1'b0;  progValid = 1'b0;  progData = '0;
        busEn = 1'b0;  busVal = '0;
        rst0 = 1'b1;  marIn0 = 1'b0;  we0 = 1'b0;  oeN0 = 1'b1;
        progMode0 = 1'b0;  progValid0 = 1'b0;  progData0 = '0;
        bus0En = 1'b0;  bus0Val = '0;
        refMar = '0;
        test_reset();
        test_run();
        test_contention();
        test_prog();
        test_prog_wrap();
        test_mid_reset();
        test_no_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
